// File: rtl/length_classifier.sv
// rtl/length_classifier.sv - object-length classifier for a row of presence sensors
module length_classifier #(
    parameter int NUM_SENSORS = 3,
    parameter int DWELL_W     = 16,
    parameter int MAX_DWELL   = 1000,
    localparam int CLS_W      = (NUM_SENSORS <= 2) ? 1 : $clog2(NUM_SENSORS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [NUM_SENSORS-1:0] sensor,
    output logic                   busy,
    output logic                   cls_valid,
    output logic [CLS_W-1:0]       cls_idx,
    output logic [NUM_SENSORS-1:0] cls_onehot,
    output logic [DWELL_W-1:0]     dwell,
    output logic                   err_valid,
    output logic [1:0]             err_code
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        STUCK   = 2'd2
    } state_t;

    localparam logic [DWELL_W-1:0] MAX_DWELL_C = DWELL_W'(MAX_DWELL);
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_GAP     = 2'b10;

    state_t                 state_q, state_d;
    logic                   s0_q;
    logic [DWELL_W-1:0]     cnt_q, cnt_d;
    logic [CLS_W-1:0]       max_q, max_d;
    logic                   gap_q, gap_d;
    logic                   busy_q, busy_d;
    logic                   cls_valid_q, cls_valid_d;
    logic [CLS_W-1:0]       cls_idx_q, cls_idx_d;
    logic [NUM_SENSORS-1:0] cls_onehot_q, cls_onehot_d;
    logic [DWELL_W-1:0]     dwell_q, dwell_d;
    logic                   err_valid_q, err_valid_d;
    logic [1:0]             err_code_q, err_code_d;

    logic [CLS_W-1:0]       hi_idx;
    logic                   non_contig;

    always_comb begin
        hi_idx = '0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            if (sensor[i]) hi_idx = CLS_W'(i);
        end
    end

    // A downstream sensor that is set after a clear one means a sensor dropped out.
    always_comb begin
        logic seen_zero;
        seen_zero  = 1'b0;
        non_contig = 1'b0;
        for (int i = 1; i < NUM_SENSORS; i++) begin
            if (!sensor[i])     seen_zero  = 1'b1;
            else if (seen_zero) non_contig = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        max_d        = max_q;
        gap_d        = gap_q;
        cls_valid_d  = 1'b0;
        cls_idx_d    = cls_idx_q;
        cls_onehot_d = cls_onehot_q;
        dwell_d      = dwell_q;
        err_valid_d  = 1'b0;
        err_code_d   = err_code_q;

        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            max_d   = '0;
            gap_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sensor[0] && !s0_q) begin
                        state_d = MEASURE;
                        cnt_d   = DWELL_W'(1);
                        max_d   = hi_idx;
                        gap_d   = non_contig;
                    end
                end
                MEASURE: begin
                    if (sensor[0]) begin
                        if (cnt_q >= MAX_DWELL_C) begin
                            state_d     = STUCK;
                            err_valid_d = 1'b1;
                            err_code_d  = ERR_TIMEOUT;
                        end else begin
                            cnt_d = cnt_q + DWELL_W'(1);
                            max_d = (hi_idx > max_q) ? hi_idx : max_q;
                            gap_d = gap_q | non_contig;
                        end
                    end else begin
                        state_d = IDLE;
                        if (gap_q) begin
                            err_valid_d = 1'b1;
                            err_code_d  = ERR_GAP;
                        end else begin
                            cls_valid_d  = 1'b1;
                            cls_idx_d    = max_q;
                            cls_onehot_d = {{(NUM_SENSORS-1){1'b0}}, 1'b1} << max_q;
                            dwell_d      = cnt_q;
                        end
                    end
                end
                STUCK: begin
                    if (!sensor[0]) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    // s0_q resets high so an object already on sensor 0 at reset release is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            s0_q         <= 1'b1;
            cnt_q        <= '0;
            max_q        <= '0;
            gap_q        <= 1'b0;
            busy_q       <= 1'b0;
            cls_valid_q  <= 1'b0;
            cls_idx_q    <= '0;
            cls_onehot_q <= '0;
            dwell_q      <= '0;
            err_valid_q  <= 1'b0;
            err_code_q   <= 2'b00;
        end else begin
            state_q      <= state_d;
            s0_q         <= sensor[0];
            cnt_q        <= cnt_d;
            max_q        <= max_d;
            gap_q        <= gap_d;
            busy_q       <= busy_d;
            cls_valid_q  <= cls_valid_d;
            cls_idx_q    <= cls_idx_d;
            cls_onehot_q <= cls_onehot_d;
            dwell_q      <= dwell_d;
            err_valid_q  <= err_valid_d;
            err_code_q   <= err_code_d;
        end
    end

    assign busy       = busy_q;
    assign cls_valid  = cls_valid_q;
    assign cls_idx    = cls_idx_q;
    assign cls_onehot = cls_onehot_q;
    assign dwell      = dwell_q;
    assign err_valid  = err_valid_q;
    assign err_code   = err_code_q;

endmodule

// File: tb/tb_length_classifier.sv
// tb/tb_length_classifier.sv - self-checking bench for length_classifier
module tb_length_classifier;

    localparam int MAXD = 20;
    localparam int P1   = 10;
    localparam int P2   = 12;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [2:0]  sensor;
    logic        busy;
    logic        cls_valid;
    logic [1:0]  cls_idx;
    logic [2:0]  cls_onehot;
    logic [15:0] dwell;
    logic        err_valid;
    logic [1:0]  err_code;

    length_classifier #(
        .NUM_SENSORS(3),
        .DWELL_W    (16),
        .MAX_DWELL  (MAXD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .sensor    (sensor),
        .busy      (busy),
        .cls_valid (cls_valid),
        .cls_idx   (cls_idx),
        .cls_onehot(cls_onehot),
        .dwell     (dwell),
        .err_valid (err_valid),
        .err_code  (err_code)
    );

    typedef struct {
        logic        is_err;
        logic [1:0]  idx;
        logic [15:0] dwell;
        logic [1:0]  code;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic push_cls(input logic [1:0] idx, input int dw);
        exp_t e;
        e.is_err = 1'b0; e.idx = idx; e.dwell = 16'(dw); e.code = 2'b00; e.cyc = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic push_err(input logic [1:0] code);
        exp_t e;
        e.is_err = 1'b1; e.idx = 2'd0; e.dwell = 16'd0; e.code = code; e.cyc = cyc + 1;
        sb.push_back(e);
    endtask

    // Drive one sample, let the DUT clock it, then retire any strobe against the scoreboard.
    task automatic cycle(input logic en, input logic [2:0] s);
        exp_t        e;
        logic [2:0]  oh;
        enable = en;
        sensor = s;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        checks++;
        if (cls_valid && err_valid) begin
            errors++;
            $display("FAIL strobe_exclusive: cls_valid=%b err_valid=%b at cyc %0d", cls_valid, err_valid, cyc);
        end
        if (cls_valid || err_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: cls_valid=%b err_valid=%b at cyc %0d, none expected", cls_valid, err_valid, cyc);
            end else begin
                e = sb.pop_front();
                if (cyc !== e.cyc) begin
                    errors++;
                    $display("FAIL strobe_cycle: got cyc %0d expected cyc %0d", cyc, e.cyc);
                end
                checks++;
                if (err_valid !== e.is_err) begin
                    errors++;
                    $display("FAIL strobe_kind: err_valid=%b expected %b", err_valid, e.is_err);
                end else if (e.is_err) begin
                    checks++;
                    if (err_code !== e.code) begin
                        errors++;
                        $display("FAIL err_code: got %b expected %b", err_code, e.code);
                    end
                end else begin
                    oh = 3'b001 << e.idx;
                    checks += 3;
                    if (cls_idx !== e.idx) begin
                        errors++;
                        $display("FAIL cls_idx: got %0d expected %0d", cls_idx, e.idx);
                    end
                    if (cls_onehot !== oh) begin
                        errors++;
                        $display("FAIL cls_onehot: got %b expected %b", cls_onehot, oh);
                    end
                    if (dwell !== e.dwell) begin
                        errors++;
                        $display("FAIL dwell: got %0d expected %0d", dwell, e.dwell);
                    end
                end
            end
        end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_strobe: cls_valid=0 err_valid=0 at cyc %0d, expected err=%b at cyc %0d", cyc, e.is_err, e.cyc);
        end
    endtask

    // Object spanning len+1 positions, head advancing one position per clock past sensors at 0, P1, P2.
    task automatic send_object(input int len);
        logic [2:0] s;
        logic [1:0] exp_idx;
        exp_idx = (P2 <= len) ? 2'd2 : (P1 <= len) ? 2'd1 : 2'd0;
        for (int t = 0; t <= len + P2 + 1; t++) begin
            s[0] = (t <= len);
            s[1] = (t >= P1) && (t <= P1 + len);
            s[2] = (t >= P2) && (t <= P2 + len);
            if (t == len + 1) push_cls(exp_idx, len + 1);
            cycle(1'b1, s);
        end
        repeat (2) cycle(1'b1, 3'b000);
    endtask

    task automatic test_reset;
        rst_n  = 1'b0;
        enable = 1'b1;
        sensor = 3'b001;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks += 7;
        if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (cls_valid !== 1'b0)  begin errors++; $display("FAIL reset_cls_valid: got %b expected 0", cls_valid); end
        if (cls_idx !== 2'd0)    begin errors++; $display("FAIL reset_cls_idx: got %0d expected 0", cls_idx); end
        if (cls_onehot !== 3'd0) begin errors++; $display("FAIL reset_cls_onehot: got %b expected 000", cls_onehot); end
        if (dwell !== 16'd0)     begin errors++; $display("FAIL reset_dwell: got %0d expected 0", dwell); end
        if (err_valid !== 1'b0)  begin errors++; $display("FAIL reset_err_valid: got %b expected 0", err_valid); end
        if (err_code !== 2'b00)  begin errors++; $display("FAIL reset_err_code: got %b expected 00", err_code); end
        rst_n = 1'b1;
        repeat (5) cycle(1'b1, 3'b001);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL preheld_busy: got %b expected 0", busy); end
        repeat (3) cycle(1'b1, 3'b000);
        send_object(9);
    endtask

    task automatic test_classes;
        send_object(9);
        send_object(11);
        send_object(12);
    endtask

    task automatic test_timeout;
        for (int k = 1; k <= 25; k++) begin
            if (k == MAXD + 1) push_err(2'b01);
            cycle(1'b1, 3'b001);
            if (k == 2 || k == 23) begin
                checks++;
                if (busy !== 1'b1) begin errors++; $display("FAIL timeout_busy_high: got %b expected 1 at high %0d", busy, k); end
            end
        end
        cycle(1'b1, 3'b000);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy_low: got %b expected 0", busy); end
        cycle(1'b1, 3'b000);
        send_object(11);
    endtask

    task automatic test_gap;
        send_object(11);
        cycle(1'b1, 3'b001);
        cycle(1'b1, 3'b001);
        cycle(1'b1, 3'b101);
        cycle(1'b1, 3'b001);
        push_err(2'b10);
        cycle(1'b1, 3'b000);
        cycle(1'b1, 3'b000);
        checks += 4;
        if (cls_idx !== 2'd1)     begin errors++; $display("FAIL gap_cls_idx_held: got %0d expected 1", cls_idx); end
        if (cls_onehot !== 3'b010) begin errors++; $display("FAIL gap_onehot_held: got %b expected 010", cls_onehot); end
        if (dwell !== 16'd12)     begin errors++; $display("FAIL gap_dwell_held: got %0d expected 12", dwell); end
        if (err_code !== 2'b10)   begin errors++; $display("FAIL gap_code_held: got %b expected 10", err_code); end
    endtask

    task automatic test_back_to_back;
        repeat (4) cycle(1'b1, 3'b001);
        push_cls(2'd0, 4);
        cycle(1'b1, 3'b000);
        cycle(1'b1, 3'b001);
        cycle(1'b1, 3'b011);
        cycle(1'b1, 3'b001);
        push_cls(2'd1, 3);
        cycle(1'b1, 3'b000);
        repeat (2) cycle(1'b1, 3'b000);
    endtask

    task automatic test_enable_drop;
        repeat (3) cycle(1'b1, 3'b001);
        repeat (2) cycle(1'b0, 3'b011);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL enable_drop_busy: got %b expected 0", busy); end
        repeat (3) cycle(1'b1, 3'b011);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL enable_resume_busy: got %b expected 0", busy); end
        repeat (3) cycle(1'b1, 3'b000);
        send_object(12);
    endtask

    task automatic test_reset_mid_pass;
        repeat (4) cycle(1'b1, 3'b001);
        rst_n = 1'b0;
        cycle(1'b1, 3'b011);
        checks += 2;
        if (busy !== 1'b0)  begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        if (dwell !== 16'd0) begin errors++; $display("FAIL midreset_dwell: got %0d expected 0", dwell); end
        rst_n = 1'b1;
        repeat (3) cycle(1'b1, 3'b011);
        repeat (3) cycle(1'b1, 3'b000);
        send_object(9);
    endtask

    initial begin
        test_reset();
        test_classes();
        test_timeout();
        test_gap();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid_pass();
        repeat (3) cycle(1'b1, 3'b000);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expected strobes never seen, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/length_classifier.md
# length_classifier

Parametrised object-length classifier for a row of presence sensors along a single-direction track. It generalises the fixed three-sensor K/M/L FSM to `NUM_SENSORS` sensors and classes, and adds a dwell-time measurement, a stuck-sensor timeout, a sensor-fault (gap) check, an enable and a reset. It sits directly behind the sensor inputs and feeds classification results to downstream counters and logging.

## Interface
- `NUM_SENSORS`, 3: number of sensors and classes, ≥2. `sensor[0]` is the reference at position 0; higher indices sit at strictly increasing downstream positions.
- `DWELL_W`, 16: width of the dwell counter.
- `MAX_DWELL`, 1000: timeout threshold in cycles. Must satisfy 1 ≤ `MAX_DWELL` < 2^`DWELL_W`.
- Derived localparam `CLS_W` = max(1, clog2(`NUM_SENSORS`)).

Ports:
- `clk`  in  1  sole clock; rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `enable`  in  1  0 aborts any measurement and holds the FSM in IDLE.
- `sensor`  in  `NUM_SENSORS`  presence inputs, synchronous to `clk`; 1 = object covers that sensor.
- `busy`  out  1  1 while the FSM is not in IDLE.
- `cls_valid`  out  1  one-cycle result strobe.
- `cls_idx`  out  `CLS_W`  class index. Holds its value until the next `cls_valid`.
- `cls_onehot`  out  `NUM_SENSORS`  one-hot of `cls_idx`. Holds its value until the next `cls_valid`.
- `dwell`  out  `DWELL_W`  number of cycles `sensor[0]` was high for the reported object. Updated together with `cls_idx`.
- `err_valid`  out  1  one-cycle error strobe.
- `err_code`  out  2  01 = timeout, 10 = gap fault. Holds its value until the next `err_valid`.

## Operation
- Class definition: the class is the highest index i for which `sensor[i]` and `sensor[0]` were sampled high in the same cycle during one object pass. Class 0 means no downstream sensor overlapped.
- Previous-sample register `s0_q` is reset to 1. An object already covering sensor 0 at reset release is therefore ignored.
- States: IDLE, MEASURE, STUCK.
- **IDLE → MEASURE** when `enable` = 1, `sensor[0]` = 1 and `s0_q` = 0. On entry:
  - `max_idx` = highest i with `sensor[i]` set in that same sample.
  - `cnt` = 1.
  - `gap` = contiguity check of that sample.
- **MEASURE, `sensor[0]` = 1**, per cycle:
  - `cnt` += 1.
  - `max_idx` = max(`max_idx`, highest set i).
  - `gap` |= non-contiguous sample. A sample is non-contiguous when some `sensor[j]` = 1 (j > 0) while some `sensor[k]` = 0 with 0 < k < j.
- **MEASURE → STUCK** when `cnt` would exceed `MAX_DWELL`. At this transition: `err_valid` = 1, `err_code` = 01, and no class result is produced.
- **MEASURE, `sensor[0]` = 0 → IDLE**:
  - If `gap` = 0: `cls_valid` = 1; `cls_idx` = `max_idx`; `cls_onehot` = 1 << `max_idx`; `dwell` = `cnt`.
  - If `gap` = 1: `err_valid` = 1, `err_code` = 10; class outputs unchanged.
- **STUCK → IDLE** when `sensor[0]` is sampled 0. No strobe is issued.
- `enable` = 0 in any state: next state is IDLE, accumulators are discarded, no strobe is issued. `s0_q` keeps tracking `sensor[0]`.
- While in MEASURE, downstream sensors count only in cycles where `sensor[0]` = 1. Downstream activity outside MEASURE is ignored; the tail of a short object may still pass downstream sensors after classification.

## Timing
- All outputs are registered.
- Reset values: `busy` 0, `cls_valid` 0, `cls_idx` 0, `cls_onehot` 0, `dwell` 0, `err_valid` 0, `err_code` 00. State = IDLE.
- Reset asserted mid-measurement: immediate return to the reset values; no strobe after release.
- Latency: `cls_valid` / `err_valid` rise at the first clock edge that samples `sensor[0]` = 0, and fall one cycle later.
- Timeout strobe rises at the edge that samples the (`MAX_DWELL`+1)-th consecutive high.
- `busy` rises at the start edge. It falls at the edge where the result or error strobe rises, or at the STUCK exit edge.
- A new rise of `sensor[0]` in the cycle right after a fall starts a new measurement. Back-to-back objects must be handled with no dead cycle.
- `cls_valid` and `err_valid` are never high in the same cycle.

## Test plan
Default parameters unless stated. Sensors at positions 0, 10 and 12; the object advances one position per clock.
- Object length 9 → `cls_valid` pulse; `cls_idx` = 0; `cls_onehot` = 001; `dwell` = 10.
- Object length 11 → `cls_idx` = 1; `cls_onehot` = 010; `dwell` = 12.
- Object length 12 → `cls_idx` = 2; `cls_onehot` = 100; `dwell` = 13.
- `MAX_DWELL` = 20, `sensor[0]` held high 25 cycles → `err_valid` with `err_code` 01 at the 21st high sample. No `cls_valid`. `busy` = 0 and state = IDLE after `sensor[0]` drops.
- One sample `sensor` = 101 inside a pass → `err_valid`, `err_code` 10 at the fall. `cls_idx` is unchanged from the previous result.
- Each of the following produces no strobe; the next object then classifies correctly:
  - `rst_n` pulsed low mid-pass.
  - `enable` dropped mid-pass.
  - `sensor[0]` already high at reset release.
